pong_frame_scheduler: RTL and testbench

//  Game sequencer and paddle-update arbiter for the Pong VGA datapath. Runs the game state

---
 rtl/pong_frame_scheduler.sv | 235 +++++++++++++++++++++++
 tb/tb_pong_frame_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_frame_scheduler.sv
// pong_frame_scheduler: Pong game sequencer plus vblank-only round-robin paddle load arbiter.
// Optional build macro PONG_SCHED_STATS_EN adds o_drop_cnt (overwritten/discarded commands).
module pong_frame_scheduler #(
    parameter int unsigned WIN_SCORE    = 3,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned Y_MAX        = 420,
    parameter int unsigned CENTER_Y     = 210
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pix_stb,
    input  logic       i_vblank,
    input  logic       i_start,
    input  logic       i_cmd_valid,
    input  logic [9:0] i_cmd_data,
    output logic       o_cmd_ready,
    input  logic [3:0] i_score,
    output logic [8:0] o_bar_y,
    output logic       o_bar_sel,
    output logic       o_bar_load,
    output logic       o_enable_pong,
    output logic       o_ball_run,
    output logic [1:0] o_state
`ifdef PONG_SCHED_STATS_EN
    ,
    output logic [7:0] o_drop_cnt
`endif
);

    localparam int unsigned Y_W     = 9;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned SCORE_W = 2;

    localparam logic [Y_W-1:0]     Y_MAX_V    = Y_W'(Y_MAX);
    localparam logic [Y_W-1:0]     CENTER_V   = Y_W'(CENTER_Y);
    localparam logic [SCORE_W-1:0] WIN_V      = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [CNT_W-1:0]    r_serve_cnt;
    logic [CNT_W-1:0]    w_serve_cnt_nx;
    logic                w_recenter;

    logic                r_vblank_q;
    logic                r_start_q;
    logic [3:0]          r_score_q;
    logic                r_cmd_ready;

    logic [Y_W-1:0]      r_val [2];
    logic [1:0]          r_pend;
    logic                r_rr;

    logic [Y_W-1:0]      r_bar_y;
    logic                r_bar_sel;
    logic                r_bar_load;
    logic                r_enable_pong;
    logic                r_ball_run;

    logic                w_accept;
    logic                w_live;
    logic                w_wr;
    logic                w_wr_slot;
    logic [Y_W-1:0]      w_req_y;
    logic [Y_W-1:0]      w_clamp_y;
    logic                w_frame_tick;
    logic                w_score_chg;
    logic                w_win;
    logic                w_start_fall;
    logic                w_grant;
    logic                w_grant_slot;

    // Command path and arbitration decode
    assign w_accept     = i_cmd_valid && r_cmd_ready;
    assign w_live       = (r_state == ST_SERVE) || (r_state == ST_PLAY);
    assign w_wr         = w_accept && w_live;
    assign w_wr_slot    = i_cmd_data[9];
    assign w_req_y      = i_cmd_data[8:0];
    assign w_clamp_y    = (w_req_y > Y_MAX_V) ? Y_MAX_V : w_req_y;
    assign w_frame_tick = i_vblank && !r_vblank_q;
    assign w_score_chg  = (i_score != r_score_q);
    assign w_win        = (i_score[1:0] >= WIN_V) || (i_score[3:2] >= WIN_V);
    assign w_start_fall = r_start_q && !i_start;
    assign w_grant      = i_pix_stb && i_vblank && (|r_pend);
    assign w_grant_slot = (&r_pend) ? r_rr : r_pend[1];

    // Game state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_serve_cnt <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_serve_cnt <= w_serve_cnt_nx;
        end
    end

    // Game next-state logic
    always_comb begin
        w_state_nx     = r_state;
        w_serve_cnt_nx = r_serve_cnt;
        w_recenter     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nx     = ST_SERVE;
                    w_serve_cnt_nx = '0;
                    w_recenter     = 1'b1;
                end
            end
            ST_SERVE: begin
                if (w_frame_tick) begin
                    if (r_serve_cnt == SERVE_LAST) begin
                        w_state_nx = ST_PLAY;
                    end else begin
                        w_serve_cnt_nx = r_serve_cnt + CNT_W'(1);
                    end
                end
            end
            ST_PLAY: begin
                if (w_score_chg) begin
                    if (w_win) begin
                        w_state_nx = ST_OVER;
                    end else begin
                        w_state_nx     = ST_SERVE;
                        w_serve_cnt_nx = '0;
                    end
                end
            end
            ST_OVER: begin
                if (w_start_fall) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Edge-detect history, handshake and game enables
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vblank_q    <= 1'b0;
            r_start_q     <= 1'b0;
            r_score_q     <= '0;
            r_cmd_ready   <= 1'b0;
            r_enable_pong <= 1'b0;
            r_ball_run    <= 1'b0;
        end else begin
            r_vblank_q    <= i_vblank;
            r_start_q     <= i_start;
            r_score_q     <= i_score;
            r_cmd_ready   <= 1'b1;
            r_enable_pong <= (w_state_nx == ST_SERVE) || (w_state_nx == ST_PLAY);
            r_ball_run    <= (w_state_nx == ST_PLAY);
        end
    end

    // Paddle slots: a write in the grant cycle re-arms the slot after the old value is loaded
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < 2; s++) begin
                r_val[s] <= CENTER_V;
            end
            r_pend <= 2'b11;
            r_rr   <= 1'b1;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (w_recenter) begin
                    r_val[s]  <= CENTER_V;
                    r_pend[s] <= 1'b1;
                end else if (w_wr && (w_wr_slot == 1'(s))) begin
                    r_val[s]  <= w_clamp_y;
                    r_pend[s] <= 1'b1;
                end else if (w_grant && (w_grant_slot == 1'(s))) begin
                    r_pend[s] <= 1'b0;
                end
            end
            if (w_grant && (&r_pend)) begin
                r_rr <= ~r_rr;
            end
        end
    end

    // Shared paddle load bus
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bar_y    <= '0;
            r_bar_sel  <= 1'b0;
            r_bar_load <= 1'b0;
        end else begin
            r_bar_load <= w_grant;
            if (w_grant) begin
                r_bar_y   <= r_val[w_grant_slot];
                r_bar_sel <= w_grant_slot;
            end
        end
    end

`ifdef PONG_SCHED_STATS_EN
    logic [7:0] r_drop_cnt;
    logic       w_drop;

    // A pending value is only lost if the same-cycle grant is not already taking it
    assign w_drop = w_accept &&
                    (!w_live || (r_pend[w_wr_slot] && !(w_grant && (w_grant_slot == w_wr_slot))));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign o_drop_cnt = r_drop_cnt;
`endif

    assign o_cmd_ready   = r_cmd_ready;
    assign o_bar_y       = r_bar_y;
    assign o_bar_sel     = r_bar_sel;
    assign o_bar_load    = r_bar_load;
    assign o_enable_pong = r_enable_pong;
    assign o_ball_run    = r_ball_run;
    assign o_state       = r_state;

endmodule

// File: tb/tb_pong_frame_scheduler.sv
// tb_pong_frame_scheduler: directed stimulus; expected paddle loads go into a queue
// that a negedge monitor drains, state/enable checks are made inline.
module tb_pong_frame_scheduler;

    typedef struct packed {
        logic       sel;
        logic [8:0] y;
    } load_t;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       stb       = 1'b0;
    logic       vblank    = 1'b1;
    logic       start     = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [9:0] cmd_data  = '0;
    logic [3:0] score     = '0;
    logic       cmd_ready;
    logic [8:0] bar_y;
    logic       bar_sel;
    logic       bar_load;
    logic       enable_pong;
    logic       ball_run;
    logic [1:0] state;
`ifdef PONG_SCHED_STATS_EN
    logic [7:0] drop_cnt;
`endif

    load_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    logic  prev_load = 1'b0;

    pong_frame_scheduler dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_pix_stb     (stb),
        .i_vblank      (vblank),
        .i_start       (start),
        .i_cmd_valid   (cmd_valid),
        .i_cmd_data    (cmd_data),
        .o_cmd_ready   (cmd_ready),
        .i_score       (score),
        .o_bar_y       (bar_y),
        .o_bar_sel     (bar_sel),
        .o_bar_load    (bar_load),
        .o_enable_pong (enable_pong),
        .o_ball_run    (ball_run),
        .o_state       (state)
`ifdef PONG_SCHED_STATS_EN
        ,
        .o_drop_cnt    (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Pixel strobe every second clock
    always @(posedge clk) stb <= ~stb;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [9:0] d);
        cmd_valid = 1'b1;
        cmd_data  = d;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic frame();
        vblank = 1'b1;
        tick(6);
        vblank = 1'b0;
        tick(4);
    endtask

    task automatic push(input logic sel, input logic [8:0] y);
        load_t e;
        e.sel = sel;
        e.y   = y;
        exp_q.push_back(e);
    endtask

    // Monitor: every load pulse must match the oldest expected load and last one cycle
    always @(negedge clk) begin
        if (bar_load) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_load: got sel=%0d y=%0d with no load expected", bar_sel, bar_y);
            end else begin
                load_t e;
                e = exp_q.pop_front();
                check("load_sel", bar_sel, e.sel);
                check("load_y", bar_y, e.y);
                check("load_pulse_width", prev_load, 0);
            end
        end
        prev_load = bar_load;
    end

    initial begin
        // Reset values
        tick(3);
        check("rst_state", state, 0);
        check("rst_load", bar_load, 0);
        check("rst_ready", cmd_ready, 0);
        check("rst_enable", enable_pong, 0);
        check("rst_ball", ball_run, 0);
        check("rst_bar_y", bar_y, 0);

        // Reset-pending centre loads, paddle 1 first
        push(1'b1, 9'd210);
        push(1'b0, 9'd210);
        rst = 1'b0;
        tick(12);
        check("t1_state", state, 0);
        check("t1_ready", cmd_ready, 1);
        check("t1_q_empty", exp_q.size(), 0);

        // Command in IDLE is discarded
        send_cmd(10'h232);
        tick(10);
`ifdef PONG_SCHED_STATS_EN
        check("idle_drop_cnt", drop_cnt, 1);
`endif

        // Start a game: recentre, pointer now at paddle 2
        vblank = 1'b0;
        tick(2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("serve_state", state, 1);
        check("serve_enable", enable_pong, 1);
        check("serve_ball", ball_run, 0);
        push(1'b0, 9'd210);
        push(1'b1, 9'd210);
        frame();
        check("recentre_q_empty", exp_q.size(), 0);

        // Clamp and latest-wins overwrite
        send_cmd(10'h3FF);
        push(1'b1, 9'd420);
        frame();
        check("clamp_q_empty", exp_q.size(), 0);
        send_cmd(10'h20A);
        send_cmd(10'h214);
        push(1'b1, 9'd20);
        frame();
        check("overwrite_q_empty", exp_q.size(), 0);
`ifdef PONG_SCHED_STATS_EN
        check("overwrite_drop_cnt", drop_cnt, 2);
`endif

        // Serve countdown: 3 frames so far
        repeat (56) frame();
        check("serve_59_state", state, 1);
        frame();
        check("play_state", state, 2);
        check("play_ball", ball_run, 1);
        check("play_enable", enable_pong, 1);

        // No loads while vblank low, then round-robin paddle 1 first
        push(1'b1, 9'd100);
        push(1'b0, 9'd200);
        send_cmd(10'h264);
        send_cmd(10'h0C8);
        tick(4);
        check("no_load_active_video", exp_q.size(), 2);
        frame();
        check("rr_q_empty", exp_q.size(), 0);
        check("rr_state", state, 2);

        // Point scored -> SERVE; score change in SERVE only updates history
        score = 4'b0001;
        tick(1);
        check("point_state", state, 1);
        check("point_ball", ball_run, 0);
        score = 4'b0010;
        tick(2);
        check("serve_score_state", state, 1);
        repeat (59) frame();
        check("serve2_59_state", state, 1);
        frame();
        check("play2_state", state, 2);

        // Winning score -> OVER
        score = 4'b0011;
        tick(1);
        check("over_state", state, 3);
        check("over_enable", enable_pong, 0);
        check("over_ball", ball_run, 0);
        send_cmd(10'h2AA);
        tick(2);
`ifdef PONG_SCHED_STATS_EN
        check("over_drop_cnt", drop_cnt, 3);
`endif
        start = 1'b1;
        tick(5);
        check("over_hold_state", state, 3);
        start = 1'b0;
        tick(1);
        check("release_state", state, 0);
        tick(3);
        check("idle_stay_state", state, 0);

        // Reset lands on the cycle of the second recentre grant
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("t6_serve_state", state, 1);
        for (int i = 0; i < 4; i++) begin
            if (stb) break;
            tick(1);
        end
        push(1'b0, 9'd210);
        vblank = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(1);
        check("t6_load_dropped", bar_load, 0);
        check("t6_state", state, 0);
        check("t6_enable", enable_pong, 0);
        check("t6_first_grant_seen", exp_q.size(), 0);
        push(1'b1, 9'd210);
        push(1'b0, 9'd210);
        rst = 1'b0;
        tick(12);
`ifdef PONG_SCHED_STATS_EN
        check("t6_drop_cnt", drop_cnt, 0);
`endif

        check("final_q_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
